// File: rtl/uart_irq_ctrl.sv
// Purpose: rising-edge interrupt latch, enable mask and fixed-priority encoder for the APB UART.
// Latency: src rise -> pend_o after 1 clk, irq_o/irq_id_o after 2 clks; ack -> irq update after 2 clks.
// Backpressure: none; edges, clears and acks are accepted every cycle, repeated edges flag overflow.
module uart_irq_ctrl #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 2
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic [NUM_SRC-1:0] src_i,
   input  logic               en_wr_i,
   input  logic [NUM_SRC-1:0] en_wdata_i,
   input  logic               clr_wr_i,
   input  logic [NUM_SRC-1:0] clr_wdata_i,
   input  logic               irq_ack_i,
   output logic [NUM_SRC-1:0] en_o,
   output logic [NUM_SRC-1:0] pend_o,
   output logic [NUM_SRC-1:0] ovf_o,
   output logic               irq_o,
   output logic [ID_W-1:0]    irq_id_o
);

   logic [NUM_SRC-1:0] prev_q, prev_d;
   logic [NUM_SRC-1:0] en_q, en_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] ovf_q, ovf_d;
   logic               irq_q, irq_d;
   logic [ID_W-1:0]    id_q, id_d;

   logic [NUM_SRC-1:0] src_rise;
   logic [NUM_SRC-1:0] clr_mask;
   logic [NUM_SRC-1:0] ack_mask;
   logic [NUM_SRC-1:0] act;

   // Edge detect, clear/ack masks and next-state for the pending/overflow/enable registers.
   always_comb begin
      src_rise = src_i & ~prev_q;
      prev_d   = src_i;
      clr_mask = clr_wr_i ? clr_wdata_i : '0;
      ack_mask = '0;
      // Ack targets the ID that is currently presented, and only while the line is up.
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_mask[i] = irq_ack_i & irq_q & (id_q == ID_W'(i));
      end
      en_d   = en_wr_i ? en_wdata_i : en_q;
      // A fresh edge wins over a same-cycle clear or ack on the same bit.
      pend_d = (pend_q & ~clr_mask & ~ack_mask) | src_rise;
      ovf_d  = (ovf_q & ~clr_mask) | (src_rise & pend_q);
   end

   // Fixed-priority encoder over the masked pending vector, index 0 highest.
   always_comb begin
      act   = pend_q & en_q;
      irq_d = |act;
      id_d  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (act[i]) begin
            id_d = ID_W'(i);
         end
      end
   end

   // State registers, all cleared asynchronously.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         prev_q <= '0;
         en_q   <= '0;
         pend_q <= '0;
         ovf_q  <= '0;
         irq_q  <= 1'b0;
         id_q   <= '0;
      end else begin
         prev_q <= prev_d;
         en_q   <= en_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         irq_q  <= irq_d;
         id_q   <= id_d;
      end
   end

   assign en_o     = en_q;
   assign pend_o   = pend_q;
   assign ovf_o    = ovf_q;
   assign irq_o    = irq_q;
   assign irq_id_o = id_q;

endmodule

// File: tb/tb_uart_irq_ctrl.sv
module tb_uart_irq_ctrl;

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic [3:0] src_i;
   logic       en_wr_i;
   logic [3:0] en_wdata_i;
   logic       clr_wr_i;
   logic [3:0] clr_wdata_i;
   logic       irq_ack_i;
   logic [3:0] en_o;
   logic [3:0] pend_o;
   logic [3:0] ovf_o;
   logic       irq_o;
   logic [1:0] irq_id_o;

   int checks = 0;
   int errors = 0;

   uart_irq_ctrl #(.NUM_SRC(4), .ID_W(2)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .src_i       (src_i),
      .en_wr_i     (en_wr_i),
      .en_wdata_i  (en_wdata_i),
      .clr_wr_i    (clr_wr_i),
      .clr_wdata_i (clr_wdata_i),
      .irq_ack_i   (irq_ack_i),
      .en_o        (en_o),
      .pend_o      (pend_o),
      .ovf_o       (ovf_o),
      .irq_o       (irq_o),
      .irq_id_o    (irq_id_o)
   );

   always #5 clk_i = ~clk_i;

   // One clock of stimulus and the register values expected right after that clock edge.
   typedef struct {
      logic [3:0] src;
      logic       en_wr;
      logic [3:0] en_wd;
      logic       clr_wr;
      logic [3:0] clr_wd;
      logic       ack;
      logic [3:0] x_en;
      logic [3:0] x_pend;
      logic [3:0] x_ovf;
      logic       x_irq;
      logic [1:0] x_id;
   } vec_t;

   vec_t vt[$];
   vec_t exp_q[$];

   function automatic vec_t mk(logic [3:0] src, logic en_wr, logic [3:0] en_wd,
                               logic clr_wr, logic [3:0] clr_wd, logic ack,
                               logic [3:0] x_en, logic [3:0] x_pend, logic [3:0] x_ovf,
                               logic x_irq, logic [1:0] x_id);
      vec_t v;
      v.src = src; v.en_wr = en_wr; v.en_wd = en_wd;
      v.clr_wr = clr_wr; v.clr_wd = clr_wd; v.ack = ack;
      v.x_en = x_en; v.x_pend = x_pend; v.x_ovf = x_ovf; v.x_irq = x_irq; v.x_id = x_id;
      return v;
   endfunction

   task automatic chk(string nm, int idx, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %b required %b", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(int idx, logic [3:0] e_en, logic [3:0] e_pend, logic [3:0] e_ovf,
                          logic e_irq, logic [1:0] e_id);
      chk("en_o",     idx, en_o,            e_en);
      chk("pend_o",   idx, pend_o,          e_pend);
      chk("ovf_o",    idx, ovf_o,           e_ovf);
      chk("irq_o",    idx, {3'b0, irq_o},   {3'b0, e_irq});
      chk("irq_id_o", idx, {2'b0, irq_id_o}, {2'b0, e_id});
   endtask

   // Drive one vector, queue its expectation, clock once and score the DUT against the queue head.
   task automatic step(vec_t v, int idx);
      vec_t e;
      src_i       = v.src;
      en_wr_i     = v.en_wr;
      en_wdata_i  = v.en_wd;
      clr_wr_i    = v.clr_wr;
      clr_wdata_i = v.clr_wd;
      irq_ack_i   = v.ack;
      exp_q.push_back(v);
      @(posedge clk_i);
      #1;
      en_wr_i   = 1'b0;
      clr_wr_i  = 1'b0;
      irq_ack_i = 1'b0;
      e = exp_q.pop_front();
      chk_all(idx, e.x_en, e.x_pend, e.x_ovf, e.x_irq, e.x_id);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000");
      $fatal(1);
   end

   initial begin
      //           src    ew en    cw clr    ack  en     pend   ovf    irq id
      // reset release with all sources high: one edge each, nothing enabled
      vt.push_back(mk(4'hF, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'hF, 4'h0, 0, 2'd0)); // 0
      vt.push_back(mk(4'h0, 0, 4'h0, 1, 4'hF, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0)); // 1
      // single source 2
      vt.push_back(mk(4'h0, 1, 4'h4, 0, 4'h0, 0, 4'h4, 4'h0, 4'h0, 0, 2'd0)); // 2
      vt.push_back(mk(4'h4, 0, 4'h0, 0, 4'h0, 0, 4'h4, 4'h4, 4'h0, 0, 2'd0)); // 3
      vt.push_back(mk(4'h4, 0, 4'h0, 0, 4'h0, 0, 4'h4, 4'h4, 4'h0, 1, 2'd2)); // 4
      vt.push_back(mk(4'h4, 0, 4'h0, 0, 4'h0, 1, 4'h4, 4'h0, 4'h0, 1, 2'd2)); // 5
      vt.push_back(mk(4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h4, 4'h0, 4'h0, 0, 2'd0)); // 6
      // priority: sources 1 and 3 together
      vt.push_back(mk(4'h0, 1, 4'hF, 0, 4'h0, 0, 4'hF, 4'h0, 4'h0, 0, 2'd0)); // 7
      vt.push_back(mk(4'hA, 0, 4'h0, 0, 4'h0, 0, 4'hF, 4'hA, 4'h0, 0, 2'd0)); // 8
      vt.push_back(mk(4'hA, 0, 4'h0, 0, 4'h0, 0, 4'hF, 4'hA, 4'h0, 1, 2'd1)); // 9
      vt.push_back(mk(4'hA, 0, 4'h0, 0, 4'h0, 1, 4'hF, 4'h8, 4'h0, 1, 2'd1)); // 10
      vt.push_back(mk(4'hA, 0, 4'h0, 0, 4'h0, 0, 4'hF, 4'h8, 4'h0, 1, 2'd3)); // 11
      vt.push_back(mk(4'hA, 0, 4'h0, 0, 4'h0, 1, 4'hF, 4'h0, 4'h0, 1, 2'd3)); // 12
      vt.push_back(mk(4'h0, 0, 4'h0, 0, 4'h0, 0, 4'hF, 4'h0, 4'h0, 0, 2'd0)); // 13
      // overflow on source 0 with everything masked; stray ack is ignored
      vt.push_back(mk(4'h0, 1, 4'h0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0)); // 14
      vt.push_back(mk(4'h1, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'h1, 4'h0, 0, 2'd0)); // 15
      vt.push_back(mk(4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'h1, 4'h0, 0, 2'd0)); // 16
      vt.push_back(mk(4'h1, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'h1, 4'h1, 0, 2'd0)); // 17
      vt.push_back(mk(4'h0, 0, 4'h0, 0, 4'h0, 1, 4'h0, 4'h1, 4'h1, 0, 2'd0)); // 18
      vt.push_back(mk(4'h0, 0, 4'h0, 1, 4'h1, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0)); // 19
      // collisions on source 2: edge beats clear, edge beats ack
      vt.push_back(mk(4'h4, 1, 4'h4, 0, 4'h0, 0, 4'h4, 4'h4, 4'h0, 0, 2'd0)); // 20
      vt.push_back(mk(4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h4, 4'h4, 4'h0, 1, 2'd2)); // 21
      vt.push_back(mk(4'h4, 0, 4'h0, 1, 4'h4, 0, 4'h4, 4'h4, 4'h4, 1, 2'd2)); // 22
      vt.push_back(mk(4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h4, 4'h4, 4'h4, 1, 2'd2)); // 23
      vt.push_back(mk(4'h4, 0, 4'h0, 0, 4'h0, 1, 4'h4, 4'h4, 4'h4, 1, 2'd2)); // 24
      vt.push_back(mk(4'h0, 0, 4'h0, 1, 4'h4, 0, 4'h4, 4'h0, 4'h0, 1, 2'd2)); // 25
      vt.push_back(mk(4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h4, 4'h0, 4'h0, 0, 2'd0)); // 26
      // set up irq_o=1 with pend 0110 before the mid-run reset
      vt.push_back(mk(4'h6, 1, 4'h6, 0, 4'h0, 0, 4'h6, 4'h6, 4'h0, 0, 2'd0)); // 27
      vt.push_back(mk(4'h6, 0, 4'h0, 0, 4'h0, 0, 4'h6, 4'h6, 4'h0, 1, 2'd1)); // 28

      // Reset with all sources high: outputs stay zero while held.
      rstn_i = 1'b0;
      src_i = 4'hF; en_wr_i = 1'b0; en_wdata_i = 4'h0;
      clr_wr_i = 1'b0; clr_wdata_i = 4'h0; irq_ack_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk_all(100, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
      rstn_i = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i], i);
      end

      // Asynchronous reset between clock edges clears everything immediately.
      #2;
      rstn_i = 1'b0;
      #1;
      chk_all(200, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
      @(posedge clk_i);
      #1;
      chk_all(201, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
      src_i  = 4'h0;
      rstn_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(mk(4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 0, 2'd0), 300 + i);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
